// File: rtl/top_pkg.sv
// Shared constants and helpers for the ReLU bank datapath.
package top_pkg;

  // Number of words in the bank and width of each signed word.
  localparam int N_WORDS = 16;
  localparam int W       = 10;
  localparam int Q_W     = N_WORDS * W;

  typedef logic [W-1:0] word_t;

  // ReLU on one two's-complement word: negative values clamp to zero,
  // non-negative values pass through unchanged (no saturation or scaling).
  function automatic word_t relu_w(input logic [W-1:0] x);
    return x[W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/top_if.sv
// Flat read bus carrying every word of the input bank side by side.
interface top_if;

  // Word i occupies rdata[W*i +: W]; word 0 sits in the LSBs.
  logic [top_pkg::Q_W-1:0] rdata;

  // The memory drives the bus, the datapath consumes it.
  modport master (output rdata);
  modport slave  (input  rdata);

endinterface

// File: rtl/top_input_mem.sv
// Preloadable input bank. Contents are filled from outside through the
// hierarchical path and are never reset or written here.
module input_mem
  import top_pkg::*;
(
  top_if.master rd
);

  // Backing store; deliberately has no write port and no reset so that
  // contents survive across rst.
  reg [W-1:0] mem_i [0:N_WORDS-1];

  // Expose every word combinationally; reads need no clock.
  generate
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_rd
      assign rd.rdata[W*gi +: W] = mem_i[gi];
    end
  endgenerate

endmodule

// File: rtl/top.sv
// Two-stage element-wise ReLU over the 16-word input bank: stage 1
// snapshots the bank, stage 2 applies ReLU and registers the packed result.
module top
  import top_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  output logic [Q_W-1:0] q
);

  // Read bus between the bank and the pipeline.
  top_if w_rd_bus ();

  input_mem S1 (
    .rd (w_rd_bus)
  );

  // Stage-1 snapshot registers, one per word.
  word_t r_snap [N_WORDS];

  // Combinational ReLU of the snapshot, packed LSB-first.
  logic [Q_W-1:0] w_relu;

  generate
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_relu
      assign w_relu[W*gi +: W] = relu_w(r_snap[gi]);
    end
  endgenerate

  // Stage 1: copy the whole bank every cycle; cleared asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_WORDS; k++) begin
        r_snap[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_WORDS; k++) begin
        r_snap[k] <= w_rd_bus.rdata[W*k +: W];
      end
    end
  end

  // Stage 2: register the clamped result; cleared asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= w_relu;
    end
  end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the ReLU bank: stimulus pushes hand-computed
// expectations tagged with a cycle number, the monitor compares on negedge.
module tb_top;

  logic         clk;
  logic         rst;
  logic [159:0] q;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int           cyc;
    logic [159:0] exp;
    string        name;
  } exp_t;

  exp_t sb[$];

  top_if mon_if ();
  assign mon_if.rdata = q;

  top dut (
    .clk (clk),
    .rst (rst),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation due at this cycle and compare.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (mon_if.rdata !== e.exp) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, mon_if.rdata, e.exp);
      end else begin
        $display("ok   %s cyc=%0d q=%h", e.name, cyc, mon_if.rdata);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_at(input int c, input logic [159:0] v, input string name);
    exp_t e;
    e.cyc  = c;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic load_mem(input logic [159:0] v);
    for (int k = 0; k < 16; k++) begin
      dut.S1.mem_i[k] = v[10*k +: 10];
    end
  endtask

  // Directed vectors and their hand-computed ReLU results.
  logic [159:0] v_pos, v_neg, v_neg_exp, v_b, v_ord;

  initial begin
    v_pos = {10'd16, 10'd15, 10'd14, 10'd13, 10'd12, 10'd11, 10'd10, 10'd9,
             10'd8,  10'd7,  10'd6,  10'd5,  10'd4,  10'd3,  10'd2,  10'd1};
    v_neg = {{10{10'd7}}, 10'd100, 10'd0, 10'b1000000001,
             10'b0111111111, 10'b1111111111, 10'b1000000000};
    v_neg_exp = {{10{10'd7}}, 10'd100, 10'd0, 10'd0, 10'd511, 10'd0, 10'd0};
    v_b   = {16{10'd3}};
    v_ord = {10'd5, 150'd0};

    // Reset held with non-zero memory: output must stay zero.
    rst = 1'b1;
    load_mem(v_pos);
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_at(cyc, 160'd0, "rst_hold");
    end

    // Release with all-zero memory: output stays zero.
    load_mem(160'd0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) expect_at(cyc + i, 160'd0, "zero_mem");
    step(4);

    // All-positive words pass through after exactly two edges.
    load_mem(v_pos);
    expect_at(cyc + 1, 160'd0, "pos_lat1");
    expect_at(cyc + 2, v_pos, "pos");
    step(3);

    // Negative clamp, including -512, -1 and +511.
    load_mem(v_neg);
    expect_at(cyc + 1, v_pos, "neg_lat1");
    expect_at(cyc + 2, v_neg_exp, "neg_clamp");
    step(3);

    // Reload: vector A held five cycles, then vector B.
    load_mem(v_pos);
    expect_at(cyc + 1, v_neg_exp, "reloadA_lat1");
    for (int i = 2; i <= 5; i++) expect_at(cyc + i, v_pos, "reloadA");
    step(5);
    load_mem(v_b);
    expect_at(cyc + 1, v_pos, "reloadB_lat1");
    expect_at(cyc + 2, v_b, "reloadB");
    step(3);

    // Async reset between edges clears q before the next edge.
    rst = 1'b1;
    expect_at(cyc,     160'd0, "arst_now");
    expect_at(cyc + 1, 160'd0, "arst_hold1");
    expect_at(cyc + 2, 160'd0, "arst_hold2");
    step(2);
    rst = 1'b0;
    expect_at(cyc + 1, 160'd0, "arst_rel1");
    expect_at(cyc + 2, v_b, "arst_recover");
    step(3);

    // Ordering: only word 15 non-zero lands in the MSBs.
    load_mem(v_ord);
    expect_at(cyc + 1, v_b, "ord_lat1");
    expect_at(cyc + 2, v_ord, "ord_msb");
    step(3);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
